job_controller: RTL and testbench
=================================

JOB_CONTROLLER -- requirements
Module: job_controller

Interface
REQ-001 Parameter NUM_WE, default 4, number of parallel work-element channels (1..16).
REQ-002 Parameter DONE_DELAY, default 2, pipeline stages between internal completion and job_out.done (1..8).
REQ-003 Parameter RESET_CYCLES, default 4, cycles work-element reset is held during flush (1..255).
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 job_in  in  JobInterfaceInput  fields used: valid, command, address, command_parity, address_parity.
REQ-007 job_out  out  JobInterfaceOutput  fields driven: running, done, yield, error.
REQ-008 we_enable  out  NUM_WE  per-channel run enable.
REQ-009 we_reset  out  1  reset to all work elements.
REQ-010 we_done  in  NUM_WE  per-channel single-cycle completion pulse.
REQ-011 we_error  in  NUM_WE  per-channel single-cycle fault pulse.
REQ-012 wed  out  64  work-element descriptor captured at START.
REQ-013 active_count  out  $clog2(NUM_WE+1)  channels enabled and not yet done.

Function
REQ-014 FSM states IDLE, RUNNING, FLUSH, DONE; job_out.yield SHALL be constant 0.
REQ-015 IDLE + valid START: next cycle RUNNING, running=1, we_enable all ones, done-mask cleared, wed<=job_in.address.
REQ-016 RUNNING: we_done[i] sets mask[i] and clears we_enable[i] next cycle; START while not IDLE ignored.
REQ-017 RUNNING, mask all ones (including bits set same cycle): next cycle DONE, running=0.
REQ-018 Any we_error bit in RUNNING: error latched = 1 + index of lowest set bit, go FLUSH.
REQ-019 Valid RESET in any state: go FLUSH, running=0, we_enable=0, error cleared; RESET beats simultaneous we_done/we_error/completion.
REQ-020 FLUSH: we_reset=1 for exactly RESET_CYCLES cycles, counter reloaded if RESET re-arrives, then DONE.
REQ-021 DONE: one internal pulse entering a DONE_DELAY-stage shift pipeline, FSM returns IDLE same cycle; job_out.done is single-cycle, DONE_DELAY cycles later.
REQ-022 error holds until next accepted START or RESET.
REQ-023 active_count = NUM_WE - popcount(mask) in RUNNING, else 0.
REQ-024 Unknown command codes ignored in all states.

Reset
REQ-025 reset_n low: state IDLE, running=0, done=0, error=0, we_enable=0, we_reset=1, wed=0, mask=0, done pipeline cleared, asynchronously.
REQ-026 we_reset SHALL deassert on first clock after reset_n rises; no done pulse results from reset_n.

Configuration
REQ-027 Macro JOB_CONTROLLER_PARITY_CHECK_EN defined: odd parity checked on command and address of every valid job_in; mismatch drops command, sets error=64'hFFFF_FFFF_FFFF_FFFF, forces FLUSH.
REQ-028 Macro undefined: parity fields ignored, no parity logic synthesised.

Structure
REQ-029 FSM state enum, error codes and command constants in CAPI package.
REQ-030 Done pipeline as sub-module done_delay_line (parameter DEPTH, async active-low reset).

Verification
REQ-031 NUM_WE=4, START addr 0x1000, we_done 0x1,0x2,0x4,0x8 on separate cycles -> wed=0x1000, active_count 4..0, done pulse 2 cycles after DONE entry.
REQ-032 START, all four we_done same cycle -> exactly one done pulse, running falls next cycle.
REQ-033 START, we_error=0x4 -> error=3, we_reset high 4 cycles, one done pulse, error held until RESET.
REQ-034 RESET coincident with final we_done -> FLUSH path taken, error=0, we_reset 4 cycles.
REQ-035 reset_n pulled low mid-RUNNING -> all outputs reset values immediately, no done pulse.
REQ-036 PARITY_CHECK_EN, START with bad command_parity -> no run, error all ones, done pulse after flush.

Source files
------------

// File: rtl/job_controller_pkg.sv
// Shared command codes, FSM state constants, error codes and job interface structs
// for the job controller.
package job_controller_pkg;

  localparam logic [7:0] CMD_START = 8'h90;
  localparam logic [7:0] CMD_RESET = 8'h80;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUNNING = 2'd1;
  localparam state_t ST_FLUSH   = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  localparam logic [63:0] ERR_NONE   = 64'h0;
  localparam logic [63:0] ERR_PARITY = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic        valid;
    logic [7:0]  command;
    logic        command_parity;
    logic [63:0] address;
    logic        address_parity;
  } job_interface_input_t;

  typedef struct packed {
    logic        running;
    logic        done;
    logic        yield;
    logic [63:0] error;
  } job_interface_output_t;

  // Fault code is 1 + index of the lowest faulting channel; 0 means no fault.
  function automatic logic [63:0] error_code(input logic [15:0] fault);
    logic [63:0] code;
    code = ERR_NONE;
    for (int i = 15; i >= 0; i--)
      if (fault[i]) code = 64'(i + 1);
    return code;
  endfunction

endpackage

// File: rtl/job_controller_done_delay_line.sv
// Fixed-depth shift line that delays the internal completion pulse onto job_out.done.
module done_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pulse,
  output logic delayed
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stage <= '0;
    else          stage <= (stage << 1) | DEPTH'(pulse);
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/job_controller.sv
// Job controller: starts NUM_WE work elements, tracks completion/faults, flushes on
// reset commands. Optional odd-parity checking under JOB_CONTROLLER_PARITY_CHECK_EN.
module job_controller
  import job_controller_pkg::*;
#(
  parameter int NUM_WE       = 4,
  parameter int DONE_DELAY   = 2,
  parameter int RESET_CYCLES = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  job_interface_input_t          job_in,
  output job_interface_output_t         job_out,
  output logic [NUM_WE-1:0]             we_enable,
  output logic                          we_reset,
  input  logic [NUM_WE-1:0]             we_done,
  input  logic [NUM_WE-1:0]             we_error,
  output logic [63:0]                   wed,
  output logic [$clog2(NUM_WE+1)-1:0]   active_count
);

  localparam int CW = $clog2(NUM_WE + 1);
  localparam int RW = 8;

  state_t            state, state_nxt;
  logic [NUM_WE-1:0] mask, mask_nxt;
  logic [RW-1:0]     flush_cnt, flush_cnt_nxt;
  logic [63:0]       error, error_nxt, wed_nxt;
  logic              parity_bad, cmd_start, cmd_reset, done_q;

`ifdef JOB_CONTROLLER_PARITY_CHECK_EN
  assign parity_bad = job_in.valid &
                      ~((^job_in.command ^ job_in.command_parity) &
                        (^job_in.address ^ job_in.address_parity));
`else
  logic unused_parity;
  assign unused_parity = job_in.command_parity ^ job_in.address_parity;
  assign parity_bad    = 1'b0;
`endif

  assign cmd_start = job_in.valid & ~parity_bad & (job_in.command == CMD_START);
  assign cmd_reset = job_in.valid & ~parity_bad & (job_in.command == CMD_RESET);

  always_comb begin
    state_nxt     = state;
    mask_nxt      = mask;
    error_nxt     = error;
    wed_nxt       = wed;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_IDLE: if (cmd_start) begin
        state_nxt = ST_RUNNING;
        mask_nxt  = '0;
        error_nxt = ERR_NONE;
        wed_nxt   = job_in.address;
      end
      ST_RUNNING: begin
        mask_nxt = mask | we_done;
        // A fault outranks a completion landing in the same cycle.
        if (|we_error) begin
          state_nxt     = ST_FLUSH;
          error_nxt     = error_code(16'(we_error));
          flush_cnt_nxt = RW'(RESET_CYCLES);
        end else if (&mask_nxt) begin
          state_nxt = ST_DONE;
        end
      end
      ST_FLUSH: begin
        flush_cnt_nxt = flush_cnt - RW'(1);
        if (flush_cnt == RW'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (cmd_reset) begin
      state_nxt     = ST_FLUSH;
      error_nxt     = ERR_NONE;
      flush_cnt_nxt = RW'(RESET_CYCLES);
    end
    if (parity_bad) begin
      state_nxt     = ST_FLUSH;
      error_nxt     = ERR_PARITY;
      flush_cnt_nxt = RW'(RESET_CYCLES);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mask      <= '0;
      flush_cnt <= '0;
      error     <= ERR_NONE;
      wed       <= '0;
      we_enable <= '0;
      we_reset  <= 1'b1;
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      flush_cnt <= flush_cnt_nxt;
      error     <= error_nxt;
      wed       <= wed_nxt;
      we_enable <= (state_nxt == ST_RUNNING) ? ~mask_nxt : '0;
      we_reset  <= (state_nxt == ST_FLUSH);
    end
  end

  done_delay_line #(.DEPTH(DONE_DELAY)) u_done (
    .clock   (clock),
    .reset_n (reset_n),
    .pulse   (state == ST_DONE),
    .delayed (done_q)
  );

  assign active_count = (state == ST_RUNNING) ? CW'(NUM_WE - $countones(mask)) : '0;
  assign job_out = '{running: (state == ST_RUNNING), done: done_q, yield: 1'b0, error: error};

endmodule

// File: tb/tb_job_controller.sv
// Randomized + directed bench for job_controller against a pending-set/countdown model.
module tb_job_controller;
  import job_controller_pkg::*;

  localparam int NUM_WE = 4, DONE_DELAY = 2, RESET_CYCLES = 4;
  localparam int CW = $clog2(NUM_WE + 1);

  logic clock = 1'b0, reset_n = 1'b0;
  job_interface_input_t  job_in;
  job_interface_output_t job_out;
  logic [NUM_WE-1:0] we_enable, we_done, we_error;
  logic              we_reset;
  logic [63:0]       wed;
  logic [CW-1:0]     active_count;

  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  job_controller #(.NUM_WE(NUM_WE), .DONE_DELAY(DONE_DELAY), .RESET_CYCLES(RESET_CYCLES)) dut (
    .clock(clock), .reset_n(reset_n), .job_in(job_in), .job_out(job_out),
    .we_enable(we_enable), .we_reset(we_reset), .we_done(we_done), .we_error(we_error),
    .wed(wed), .active_count(active_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: running flag + set of channels still pending, flush countdown,
  // one-cycle "finishing" flag, and a list of cycles at which done must appear.
  bit              m_run, m_fin;
  bit [NUM_WE-1:0] m_pend;
  int              m_flush;
  logic [63:0]     m_wed, m_err;
  int              done_due[$];
  int              cyc_n = 0;

  task automatic model_clear();
    m_run = 0; m_fin = 0; m_pend = '0; m_flush = 0; m_wed = '0; m_err = '0;
    done_due.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] cmd, input logic [63:0] addr,
                            input logic [NUM_WE-1:0] d, input logic [NUM_WE-1:0] e,
                            input bit bad_par);
    bit is_start, is_reset, nf;
    is_start = v && cmd == CMD_START;
    is_reset = v && cmd == CMD_RESET;
    nf = 0;
    if (m_fin) done_due.push_back(cyc_n - 1 + DONE_DELAY);
`ifdef JOB_CONTROLLER_PARITY_CHECK_EN
    if (v && bad_par) begin
      m_run = 0; m_flush = RESET_CYCLES; m_err = '1; m_fin = 0;
      return;
    end
`else
    if (bad_par) $display("note: parity corruption ignored in this build");
`endif
    if (is_reset) begin
      m_run = 0; m_flush = RESET_CYCLES; m_err = '0;
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) nf = 1;
    end else if (m_run) begin
      if (e != 0) begin
        for (int i = 0; i < NUM_WE; i++)
          if (e[i]) begin m_err = 64'(i + 1); break; end
        m_run = 0; m_flush = RESET_CYCLES;
      end else begin
        m_pend &= ~d;
        if (m_pend == 0) begin m_run = 0; nf = 1; end
      end
    end else if (!m_fin && is_start) begin
      m_run = 1; m_pend = '1; m_wed = addr; m_err = '0;
    end
    m_fin = nf;
  endtask

  task automatic compare_all();
    bit exp_done;
    exp_done = done_due.size() > 0 && done_due[0] == cyc_n;
    if (exp_done) void'(done_due.pop_front());
    chk("running",  job_out.running, m_run);
    chk("done",     job_out.done,    exp_done);
    chk("yield",    job_out.yield,   0);
    chk("error",    job_out.error,   m_err);
    chk("we_en",    we_enable,       m_run ? m_pend : '0);
    chk("we_reset", we_reset,        m_flush > 0);
    chk("wed",      wed,             m_wed);
    chk("active",   active_count,    m_run ? $countones(m_pend) : 0);
  endtask

  task automatic drive(input bit v, input logic [7:0] cmd, input logic [63:0] addr,
                       input logic [NUM_WE-1:0] d, input logic [NUM_WE-1:0] e,
                       input bit bad_par = 0);
    @(negedge clock);
    job_in.valid          = v;
    job_in.command        = cmd;
    job_in.address        = addr;
    job_in.command_parity = (~^cmd) ^ bad_par;
    job_in.address_parity = ~^addr;
    we_done  = d;
    we_error = e;
    @(posedge clock);
    cyc_n++;
    model_step(v, cmd, addr, d, e, bad_par);
    #1 compare_all();
  endtask

  task automatic idle(input int n, inout int rst_hi, inout int dones);
    for (int i = 0; i < n; i++) begin
      drive(0, 8'h00, 64'h0, '0, '0);
      rst_hi += int'(we_reset);
      dones  += int'(job_out.done);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_running"}, job_out.running, 0);
    chk({tag, "_done"},    job_out.done,    0);
    chk({tag, "_error"},   job_out.error,   0);
    chk({tag, "_we_en"},   we_enable,       0);
    chk({tag, "_we_rst"},  we_reset,        1);
    chk({tag, "_wed"},     wed,             0);
    chk({tag, "_active"},  active_count,    0);
  endtask

  initial begin
    int rh, dn, r;
    bit v, bp;
    logic [7:0] cmd;
    logic [NUM_WE-1:0] d, e;

    job_in = '0; we_done = '0; we_error = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 chk_reset_vals("por");
    @(negedge clock) reset_n = 1'b1;
    #1 chk("por_we_reset_hold", we_reset, 1);
    drive(0, 8'h00, 64'h0, '0, '0);
    chk("por_we_reset_drop", we_reset, 0);

    // Channels finish one per cycle.
    drive(1, CMD_START, 64'h1000, '0, '0);
    chk("d31_wed", wed, 64'h1000);
    chk("d31_act", active_count, 4);
    for (int i = 0; i < NUM_WE; i++) begin
      drive(0, 8'h00, 64'h0, NUM_WE'(1 << i), '0);
      chk("d31_act_step", active_count, 64'(NUM_WE - 1 - i));
    end
    drive(0, 8'h00, 64'h0, '0, '0);
    chk("d31_done_early", job_out.done, 0);
    drive(0, 8'h00, 64'h0, '0, '0);
    chk("d31_done_pulse", job_out.done, 1);
    drive(0, 8'h00, 64'h0, '0, '0);
    chk("d31_done_single", job_out.done, 0);

    // All channels finish together.
    drive(1, CMD_START, 64'h2000, '0, '0);
    drive(0, 8'h00, 64'h0, '1, '0);
    chk("d32_running_fall", job_out.running, 0);
    rh = 0; dn = 0;
    idle(4, rh, dn);
    chk("d32_one_done", dn, 1);

    // Fault on channel 2.
    drive(1, CMD_START, 64'h3000, '0, '0);
    drive(0, 8'h00, 64'h0, '0, 4'h4);
    chk("d33_error", job_out.error, 3);
    rh = int'(we_reset); dn = 0;
    idle(6, rh, dn);
    chk("d33_rst_cycles", rh, RESET_CYCLES);
    chk("d33_one_done", dn, 1);
    chk("d33_error_held", job_out.error, 3);
    drive(1, CMD_RESET, 64'h0, '0, '0);
    chk("d33_error_clr", job_out.error, 0);
    rh = 0; dn = 0;
    idle(7, rh, dn);

    // RESET coincides with the final completion.
    drive(1, CMD_START, 64'h4000, '0, '0);
    drive(0, 8'h00, 64'h0, 4'h7, '0);
    drive(1, CMD_RESET, 64'h0, 4'h8, '0);
    chk("d34_error", job_out.error, 0);
    chk("d34_running", job_out.running, 0);
    rh = int'(we_reset); dn = 0;
    idle(6, rh, dn);
    chk("d34_rst_cycles", rh, RESET_CYCLES);
    chk("d34_one_done", dn, 1);

    // Asynchronous reset mid-run.
    drive(1, CMD_START, 64'h5000, '0, '0);
    drive(0, 8'h00, 64'h0, 4'h1, '0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("mid");
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    model_clear();
    rh = 0; dn = 0;
    idle(4, rh, dn);
    chk("mid_no_done", dn, 0);

`ifdef JOB_CONTROLLER_PARITY_CHECK_EN
    drive(1, CMD_START, 64'h6000, '0, '0, 1);
    chk("par_running", job_out.running, 0);
    chk("par_error", job_out.error, 64'hFFFF_FFFF_FFFF_FFFF);
    rh = int'(we_reset); dn = 0;
    idle(7, rh, dn);
    chk("par_rst_cycles", rh, RESET_CYCLES);
    chk("par_one_done", dn, 1);
`endif

    for (int n = 0; n < 3000; n++) begin
      v = $urandom_range(99) < 30;
      r = $urandom_range(99);
      cmd = (r < 60) ? CMD_START : (r < 75) ? CMD_RESET : 8'($urandom);
      d = NUM_WE'($urandom) & NUM_WE'($urandom);
      e = ($urandom_range(99) < 4) ? NUM_WE'($urandom) : '0;
      bp = 0;
`ifdef JOB_CONTROLLER_PARITY_CHECK_EN
      bp = $urandom_range(99) < 3;
`endif
      drive(v, cmd, {$urandom, $urandom}, d, e, bp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
